// File: rtl/key_debounce_edge.sv
// key_debounce_edge: synchronise, debounce and normalise raw pushbuttons
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   key_raw      in   raw pushbutton pins, asynchronous to clk
//   capture_clr  in   per-key clear of the sticky capture bits
//   key_level    out  debounced level, 1 = pressed
//   key_press    out  one-cycle pulse when key_level rises
//   key_release  out  one-cycle pulse when key_level falls
//   key_capture  out  sticky press flag, cleared by capture_clr
module key_debounce_edge #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_KEYS-1:0] capture_clr,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_capture
);
    typedef enum logic {IDLE, COUNT} state_t;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic SYNC_RST = (ACTIVE_LOW != 0);
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        state_t                 state_q;
        logic                   level_q, press_q, release_q, capture_q;
        logic                   s;
        assign s = SYNC_RST ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q    <= {SYNC_STAGES{SYNC_RST}};
                cnt_q     <= '0;
                state_q   <= IDLE;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                capture_q <= 1'b0;
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], key_raw[k]};
                press_q   <= 1'b0;
                release_q <= 1'b0;
                // set wins over clear so a press coinciding with a clear is not lost
                capture_q <= press_q | (capture_q & ~capture_clr[k]);
                case (state_q)
                    IDLE: begin
                        if (s != level_q) begin
                            // a single required sample means the change is accepted at once
                            if (DEBOUNCE_CYCLES == 1) begin
                                level_q   <= s;
                                press_q   <= s;
                                release_q <= ~s;
                            end else begin
                                state_q <= COUNT;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        if (s == level_q) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            level_q   <= s;
                            press_q   <= s;
                            release_q <= ~s;
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
        assign key_level[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_capture[k] = capture_q;
    end
endmodule
